// File: rtl/sdm_pkg.sv
// Shared types and defaults for the SDM sample-clock sequencer.
// Holds state encoding, reset defaults and the cfg record.
package sdm_pkg;

  localparam int SDM_WIDTH       = 17;
  localparam int SDM_OSR_W       = 10;
  localparam int SDM_DIV_DEFAULT = 5000;
  localparam int SDM_OSR_DEFAULT = 128;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } sdm_state_e;

  // Sized for the default divider/OSR widths.
  typedef struct packed {
    logic [SDM_WIDTH-1:0] div;
    logic [SDM_OSR_W-1:0] osr;
  } sdm_cfg_t;

  function automatic logic cfg_legal(sdm_cfg_t c);
    return (c.div != '0) && (c.osr != '0);
  endfunction

endpackage

// File: rtl/sdm_half_div.sv
// Half-period divider: toggles clk_out every div enabled cycles.
// Ports: clk, rst_n, en, restart, div -> clk_out, rise, fall.
module sdm_half_div
  import sdm_pkg::*;
#(
  parameter int WIDTH = SDM_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             restart,
  input  logic [WIDTH-1:0] div,
  output logic             clk_out,
  output logic             rise,
  output logic             fall
);

  localparam logic [WIDTH:0] ONE = 1;

  logic [WIDTH-1:0] r_q, r_d;
  logic             clk_q, clk_d;
  logic             tick;

  assign tick = en &&
    (({1'b0, r_q} + ONE) == {1'b0, div});

  // rise/fall flag the edge that lands on
  // the next clock, so callers can register.
  assign rise = tick & ~clk_q;
  assign fall = tick & clk_q;

  always_comb begin
    r_d   = r_q;
    clk_d = clk_q;
    if (!en || restart) begin
      r_d   = '0;
      clk_d = 1'b0;
    end else if (tick) begin
      r_d   = '0;
      clk_d = ~clk_q;
    end else begin
      r_d = r_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_q   <= '0;
      clk_q <= 1'b0;
    end else begin
      r_q   <= r_d;
      clk_q <= clk_d;
    end
  end

  assign clk_out = clk_q;

endmodule

// File: rtl/sdm_clk_sequencer.sv
// Run/stop sequencer for the modulator sample clock, framed by OSR.
// Ports: cfg_div/osr/wr, start, stop -> busy, clk_out, strobes, cnt, err.
module sdm_clk_sequencer
  import sdm_pkg::*;
#(
  parameter int WIDTH       = SDM_WIDTH,
  parameter int DIV_DEFAULT = SDM_DIV_DEFAULT,
  parameter int OSR_W       = SDM_OSR_W,
  parameter int OSR_DEFAULT = SDM_OSR_DEFAULT,
  parameter int FCNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WIDTH-1:0]  cfg_div,
  input  logic [OSR_W-1:0]  cfg_osr,
  input  logic              cfg_wr,
  input  logic              start,
  input  logic              stop,
  output logic              busy,
  output logic              clk_out,
  output logic              sample_stb,
  output logic              frame_done,
  output logic [FCNT_W-1:0] frame_cnt,
  output logic              cfg_err
);

  localparam logic [OSR_W:0] P_ONE = 1;

  sdm_state_e        state_q, state_d;
  sdm_cfg_t          act_q, act_d;
  sdm_cfg_t          shd_q, shd_d;
  sdm_cfg_t          cfg_in;
  logic              pend_q, pend_d;
  logic [OSR_W-1:0]  p_q, p_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
  logic              stb_q, stb_d;
  logic              fd_q, fd_d;
  logic              err_q, err_d;

  logic en, rise, fall;
  logic frame_end, wr_ok;

  assign cfg_in = '{div: cfg_div, osr: cfg_osr};
  assign wr_ok  = cfg_wr && cfg_legal(cfg_in);
  assign en     = (state_q != ST_IDLE);

  assign frame_end = fall &&
    (({1'b0, p_q} + P_ONE) == {1'b0, act_q.osr});

  sdm_half_div #(
    .WIDTH (WIDTH)
  ) u_div (
    .clk     (clk),
    .rst_n   (reset),
    .en      (en),
    .restart (frame_end),
    .div     (act_q.div),
    .clk_out (clk_out),
    .rise    (rise),
    .fall    (fall)
  );

  always_comb begin
    state_d = state_q;
    act_d   = act_q;
    shd_d   = shd_q;
    pend_d  = pend_q;
    p_d     = p_q;
    fcnt_d  = fcnt_q;
    err_d   = err_q;
    stb_d   = rise;
    fd_d    = frame_end;

    if (cfg_wr)
      err_d = !wr_ok;

    if (!en || frame_end)
      p_d = '0;
    else if (fall)
      p_d = p_q + OSR_W'(1);

    if (frame_end)
      fcnt_d = fcnt_q + FCNT_W'(1);

    unique case (1'b1)
      (state_q == ST_IDLE): begin
        if (start && !stop)
          state_d = ST_RUN;
      end
      (state_q == ST_RUN): begin
        // stop on the closing cycle ends here
        if (stop)
          state_d = frame_end ? ST_IDLE
                              : ST_DRAIN;
      end
      (state_q == ST_DRAIN): begin
        if (frame_end)
          state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Running config only moves at a frame
    // boundary; a coincident write wins.
    if (!en) begin
      if (wr_ok)
        act_d = cfg_in;
    end else if (frame_end) begin
      if (wr_ok)
        act_d = cfg_in;
      else if (pend_q)
        act_d = shd_q;
      pend_d = 1'b0;
    end else if (wr_ok) begin
      shd_d  = cfg_in;
      pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      act_q.div <= SDM_WIDTH'(DIV_DEFAULT);
      act_q.osr <= SDM_OSR_W'(OSR_DEFAULT);
      shd_q.div <= SDM_WIDTH'(DIV_DEFAULT);
      shd_q.osr <= SDM_OSR_W'(OSR_DEFAULT);
      pend_q    <= 1'b0;
      p_q       <= '0;
      fcnt_q    <= '0;
      stb_q     <= 1'b0;
      fd_q      <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      act_q   <= act_d;
      shd_q   <= shd_d;
      pend_q  <= pend_d;
      p_q     <= p_d;
      fcnt_q  <= fcnt_d;
      stb_q   <= stb_d;
      fd_q    <= fd_d;
      err_q   <= err_d;
    end
  end

  assign busy       = en;
  assign sample_stb = stb_q;
  assign frame_done = fd_q;
  assign frame_cnt  = fcnt_q;
  assign cfg_err    = err_q;

endmodule

// File: tb/tb_sdm_clk_sequencer.sv
// Scoreboard bench for sdm_clk_sequencer.
// Strobe cycles predicted from div/osr, checked on negedge.
module tb_sdm_clk_sequencer;

  localparam int WIDTH  = 17;
  localparam int OSR_W  = 10;
  localparam int FCNT_W = 10;
  localparam int FMOD   = 1 << FCNT_W;

  logic              clk;
  logic              reset;
  logic [WIDTH-1:0]  cfg_div;
  logic [OSR_W-1:0]  cfg_osr;
  logic              cfg_wr;
  logic              start;
  logic              stop;
  logic              busy;
  logic              clk_out;
  logic              sample_stb;
  logic              frame_done;
  logic [FCNT_W-1:0] frame_cnt;
  logic              cfg_err;

  sdm_clk_sequencer #(
    .FCNT_W (FCNT_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cfg_div    (cfg_div),
    .cfg_osr    (cfg_osr),
    .cfg_wr     (cfg_wr),
    .start      (start),
    .stop       (stop),
    .busy       (busy),
    .clk_out    (clk_out),
    .sample_stb (sample_stb),
    .frame_done (frame_done),
    .frame_cnt  (frame_cnt),
    .cfg_err    (cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nvec = 0;
  int nerr = 0;
  int exp_fc = 0;

  int stb_q[$];
  int fd_q[$];
  int fc_q[$];

  task automatic chk(input string tag,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s got=%0d want=%0d @%0d",
               tag, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin : mon
    int e;
    int c;
    if (sample_stb === 1'b1) begin
      if (stb_q.size() == 0) begin
        chk("stb_extra", 1, 0);
      end else begin
        e = stb_q.pop_front();
        chk("stb_cyc", cyc, e);
        chk("stb_clk", clk_out, 1);
      end
    end
    if (frame_done === 1'b1) begin
      if (fd_q.size() == 0) begin
        chk("fd_extra", 1, 0);
      end else begin
        e = fd_q.pop_front();
        c = fc_q.pop_front();
        chk("fd_cyc", cyc, e);
        chk("fd_cnt", frame_cnt, c);
        chk("fd_clk", clk_out, 0);
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic tick_to(input int c);
    while (cyc < c) step();
  endtask

  task automatic cfg(input int d, input int o);
    cfg_div = WIDTH'(d);
    cfg_osr = OSR_W'(o);
    cfg_wr  = 1'b1;
    step();
    cfg_wr  = 1'b0;
  endtask

  task automatic do_start(output int e0);
    start = 1'b1;
    e0 = cyc + 1;
    step();
    start = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  task automatic push_frame(input int e,
                            input int d,
                            input int o,
                            output int e_end);
    for (int k = 0; k < o; k++)
      stb_q.push_back(e + d + 2 * d * k);
    e_end  = e + 2 * d * o;
    exp_fc = (exp_fc + 1) % FMOD;
    fd_q.push_back(e_end);
    fc_q.push_back(exp_fc);
  endtask

  task automatic drain(input int limit);
    int t;
    t = cyc + limit;
    while ((stb_q.size() != 0 ||
            fd_q.size() != 0) && cyc < t)
      step();
    chk("drain_q",
        stb_q.size() + fd_q.size(), 0);
  endtask

  task automatic chk_idle(input string tag);
    repeat (6) step();
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_clk"}, clk_out, 0);
  endtask

  initial begin : wdog
    #5_000_000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin : stim
    int e0, e1, e2, e3;
    reset   = 1'b0;
    cfg_div = '0;
    cfg_osr = '0;
    cfg_wr  = 1'b0;
    start   = 1'b0;
    stop    = 1'b0;
    repeat (3) step();
    reset = 1'b1;

    // defaults after reset
    repeat (20000) step();
    chk("rst_clk", clk_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_stb", sample_stb, 0);
    chk("rst_fd", frame_done, 0);
    chk("rst_cnt", frame_cnt, 0);
    chk("rst_err", cfg_err, 0);

    // basic frames, start in RUN ignored
    cfg(2, 4);
    do_start(e0);
    chk("run_busy", busy, 1);
    push_frame(e0, 2, 4, e1);
    push_frame(e1, 2, 4, e2);
    tick_to(e0 + 5);
    start = 1'b1;
    step();
    start = 1'b0;
    tick_to(e1 + 8);
    do_stop();
    drain(100);
    chk_idle("stop2");
    chk("cnt2", frame_cnt, 2);

    // graceful stop mid-frame, start in DRAIN
    cfg(3, 2);
    do_start(e0);
    push_frame(e0, 3, 2, e1);
    tick_to(e0 + 4);
    do_stop();
    tick_to(e0 + 6);
    start = 1'b1;
    step();
    start = 1'b0;
    drain(100);
    chk_idle("stop3a");

    // stop on the frame-closing cycle
    do_start(e0);
    push_frame(e0, 3, 2, e1);
    push_frame(e1, 3, 2, e2);
    tick_to(e2 - 1);
    do_stop();
    drain(100);
    chk_idle("stop3b");
    chk("cnt3", frame_cnt, 5);

    // shadow reconfig, later write wins
    cfg(2, 4);
    do_start(e0);
    push_frame(e0, 2, 4, e1);
    tick_to(e0 + 3);
    cfg(3, 3);
    tick_to(e0 + 5);
    cfg(1, 3);
    push_frame(e1, 1, 3, e2);
    // write on the boundary cycle
    tick_to(e2 - 1);
    cfg(2, 2);
    push_frame(e2, 2, 2, e3);
    tick_to(e3 - 1);
    do_stop();
    drain(100);
    chk_idle("shd");

    // illegal configs are ignored
    cfg(0, 5);
    chk("err_div0", cfg_err, 1);
    cfg(4, 0);
    chk("err_osr0", cfg_err, 1);
    do_start(e0);
    push_frame(e0, 2, 2, e1);
    tick_to(e1 - 1);
    do_stop();
    drain(100);
    chk_idle("ill");
    chk("err_keep", cfg_err, 1);
    cfg(1, 1);
    chk("err_clr", cfg_err, 0);

    // frame counter wrap at div=1 osr=1
    do_start(e0);
    e1 = e0;
    for (int n = 0; n < FMOD + 3; n++)
      push_frame(e1, 1, 1, e1);
    tick_to(e1 - 1);
    do_stop();
    drain(5000);
    chk_idle("wrap");
    chk("wrap_cnt", frame_cnt, exp_fc);

    // start+stop together stays idle
    start = 1'b1;
    stop  = 1'b1;
    step();
    start = 1'b0;
    stop  = 1'b0;
    chk_idle("ss");

    // reset mid-frame with defaults
    reset = 1'b0;
    step();
    reset = 1'b1;
    exp_fc = 0;
    cfg(0, 0);
    chk("err_pre", cfg_err, 1);
    do_start(e0);
    stb_q.push_back(e0 + 5000);
    tick_to(e0 + 5003);
    chk("pre_clk", clk_out, 1);
    reset = 1'b0;
    step();
    chk("mid_clk", clk_out, 0);
    chk("mid_busy", busy, 0);
    chk("mid_stb", sample_stb, 0);
    chk("mid_fd", frame_done, 0);
    chk("mid_cnt", frame_cnt, 0);
    chk("mid_err", cfg_err, 0);
    reset = 1'b1;
    repeat (10) step();
    chk("mid_q",
        stb_q.size() + fd_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule

// File: doc/sdm_clk_sequencer.md
Name: sdm_clk_sequencer

Overview:
Run/stop controller for the modulator sample clock. Owns a half-period divider counter and sequences it in frames of OSR output periods. Runtime configuration of divide ratio and OSR is shadowed and applied only at frame boundaries. Emits per-sample and per-frame strobes to the decimator and the host interface. Sits between the host register interface and the ADC/decimator clock domain logic.

Parameters:
WIDTH, 17, width of divider counter and cfg_div
DIV_DEFAULT, 5000, half-period length in clk cycles after reset
OSR_W, 10, width of OSR counter and cfg_osr
OSR_DEFAULT, 128, output periods per frame after reset
FCNT_W, 16, width of frame_cnt

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-low reset; 0 = reset
cfg_div  in  WIDTH  requested half-period in clk cycles; legal range 1..2^WIDTH-1
cfg_osr  in  OSR_W  requested periods per frame; legal range 1..2^OSR_W-1
cfg_wr  in  1  one-cycle config write strobe
start  in  1  one-cycle start request
stop  in  1  one-cycle stop request; current frame is completed first
busy  out  1  high in RUN and DRAIN
clk_out  out  1  divided clock, 50% duty, period 2*div clk cycles
sample_stb  out  1  one-cycle pulse on the clk cycle in which clk_out goes 0->1
frame_done  out  1  one-cycle pulse when the osr-th period completes (clk_out goes 1->0)
frame_cnt  out  FCNT_W  completed frames since reset; wraps to 0
cfg_err  out  1  sticky; set by a cfg_wr with cfg_div==0 or cfg_osr==0; cleared by reset or by a legal cfg_wr

Behaviour:
- Reset (reset==0 at a clk edge): state IDLE, div_act=DIV_DEFAULT, osr_act=OSR_DEFAULT, no pending config, counters 0, all outputs 0.
- States: IDLE, RUN, DRAIN.
- IDLE: clk_out held 0, counters held 0.
  - start -> RUN next cycle.
  - start and stop in the same cycle -> stay IDLE.
- RUN: divider counter r increments each cycle.
  - When r+1 == div_act: r<=0 and clk_out toggles.
  - div_act==1 therefore toggles every cycle.
  - First rising edge of clk_out occurs div_act cycles after entering RUN.
- sample_stb: registered, asserted in the same cycle clk_out becomes 1.
- Period counter p increments on each falling edge.
  - On the falling edge where p+1 == osr_act: p<=0, frame_done=1, frame_cnt++.
- stop in RUN -> DRAIN.
  - DRAIN continues identically until the next frame_done.
  - At that frame_done: enter IDLE; clk_out is already 0 from the falling edge.
  - stop in the same cycle as frame_done: the current frame is the last; go straight to IDLE.
  - start in DRAIN: ignored.
  - start in RUN: ignored.
- cfg_wr with a legal value:
  - In IDLE: loads div_act/osr_act directly; takes effect next cycle.
  - In RUN/DRAIN: stores into shadow and sets pending; a later write overwrites the shadow.
  - At the next frame_done: shadow is copied to active, pending clears, r and p restart at 0.
  - cfg_wr in the same cycle as frame_done: the new value is applied at that boundary.
- cfg_wr with an illegal value: ignored (active and shadow unchanged); cfg_err set.
- frame_cnt wraps 2^FCNT_W-1 -> 0 without a flag.
- Mid-operation reset: immediate return to reset values. No partial-frame strobe.
- No combinational path from inputs to outputs.

Decomposition:
- Shared package sdm_pkg:
  - state enum (IDLE/RUN/DRAIN)
  - DIV_DEFAULT, OSR_DEFAULT
  - cfg record type {div, osr}
- One natural sub-module: sdm_half_div. It holds the r counter and toggle with inputs en, div, restart and outputs clk_out, rise, fall. Its toggle and reset semantics match the existing divider, with the reset changed to synchronous active-low.
- Sequencer FSM, shadow config and frame counter stay in the top.

Test Plan:
1. Reset defaults: release reset, wait 20000 cycles -> clk_out=0, busy=0, no strobes, frame_cnt=0, cfg_err=0.
2. Basic frame: cfg_wr div=2 osr=4 in IDLE, then start.
   - First sample_stb 2 cycles after RUN entry.
   - clk_out period 4 cycles; 4 sample_stb.
   - frame_done 16 cycles after RUN entry; frame_cnt=1.
   - Frames continue back to back.
3. Graceful stop: running div=3 osr=2; pulse stop mid-frame -> frame completes (frame_done, frame_cnt+1), then IDLE, clk_out=0, busy=0. Also cover stop coincident with frame_done.
4. Shadow reconfig: running div=2 osr=4; cfg_wr div=1 osr=3 mid-frame -> current frame keeps period 4; following frame has period 2, 3 stb, frame length 6. Also cover cfg_wr coincident with frame_done.
5. Illegal config: cfg_wr div=0 -> cfg_err=1, behaviour unchanged; subsequent legal cfg_wr clears cfg_err.
6. Reset mid-frame and wrap:
   - Assert reset during RUN -> all outputs 0 next cycle, no frame_done.
   - Preload-by-running div=1 osr=1 for 65536 frames -> frame_cnt wraps to 0.
   - start+stop together in IDLE -> stays IDLE.
